dt: RTL

//  Data-side address-translation stage; sits between EX and DC in the load/store pipe.

---
 rtl/dt_if.sv | 27 ++
 rtl/dt.sv | 59 +++++
 2 files changed

// File: rtl/dt_if.sv
// dt_if: EX->DT->DC load/store translation bus, TLB write port and exception flags.
interface dt_if #(
    parameter int EX_TO_DT_WD = 272,
    parameter int DT_TO_DC_WD = 275,
    parameter int IW          = 4
);
    logic                   flush;
    logic [5:0]             stall;
    logic [EX_TO_DT_WD-1:0] ex_to_dt_bus;
    logic [7:0]             asid;
    logic                   tlb_we;
    logic [IW-1:0]          tlb_index;
    logic [77:0]            tlb_wdata;
    logic [DT_TO_DC_WD-1:0] dt_to_dc_bus;
    logic                   d_refill;
    logic                   d_invalid;
    logic                   d_modify;
    logic                   d_uncached;
    modport master (
        output flush, stall, ex_to_dt_bus, asid, tlb_we, tlb_index, tlb_wdata,
        input  dt_to_dc_bus, d_refill, d_invalid, d_modify, d_uncached
    );
    modport slave (
        input  flush, stall, ex_to_dt_bus, asid, tlb_we, tlb_index, tlb_wdata,
        output dt_to_dc_bus, d_refill, d_invalid, d_modify, d_uncached
    );
endinterface

// File: rtl/dt.sv
// dt: data address translation stage with a fully-associative TLB between EX and DC.
module dt #(
    parameter int EX_TO_DT_WD = 272,
    parameter int DT_TO_DC_WD = 275,
    parameter int TLB_NUM     = 16
) (
    input logic clk,
    input logic rst,
    dt_if.slave bus
);
    logic [EX_TO_DT_WD-1:0] r_ex;
    logic [77:0]            r_tlb [TLB_NUM];
    logic [31:0]            w_vaddr;
    logic                   w_we;
    logic                   w_en;
    logic                   w_unmapped;
    logic                   w_hit;
    logic [77:0]            w_ent;
    logic [24:0]            w_pg;
    logic [31:0]            w_paddr;
    logic                   w_unused;
    always_ff @(posedge clk) begin
        if (!rst)
            r_ex <= '0;
        else if (bus.flush || (bus.stall[4] && !bus.stall[5]))
            r_ex <= '0;
        else if (!bus.stall[4])
            r_ex <= bus.ex_to_dt_bus;
    end
    // TLB writes ignore stall/flush; lookups this cycle still see the old entry
    always_ff @(posedge clk) begin
        if (!rst)
            for (int i = 0; i < TLB_NUM; i++) r_tlb[i] <= '0;
        else if (bus.tlb_we)
            r_tlb[bus.tlb_index] <= bus.tlb_wdata;
    end
    assign w_vaddr    = r_ex[31:0];
    assign w_we       = r_ex[32];
    assign w_en       = r_ex[33];
    assign w_unmapped = w_vaddr[31:30] == 2'b10;
    assign w_unused   = ^bus.stall[3:0];
    // scan downward so the lowest matching index is the one left standing
    always_comb begin
        w_hit = 1'b0;
        w_ent = '0;
        for (int i = TLB_NUM - 1; i >= 0; i--)
            if (r_tlb[i][77:59] == w_vaddr[31:13] && (r_tlb[i][50] || r_tlb[i][58:51] == bus.asid)) begin
                w_hit = 1'b1;
                w_ent = r_tlb[i];
            end
    end
    assign w_pg    = w_vaddr[12] ? w_ent[24:0] : w_ent[49:25];
    assign w_paddr = w_unmapped ? {3'b0, w_vaddr[28:0]} : w_hit ? {w_pg[24:5], w_vaddr[11:0]} : 32'd0;
    assign bus.dt_to_dc_bus = {r_ex[271:150], 3'b0, r_ex[149:32], w_paddr};
    assign bus.d_uncached   = w_unmapped ? w_vaddr[29] : (w_hit && w_pg[4:2] == 3'd2);
    assign bus.d_refill     = w_en && !w_unmapped && !w_hit;
    assign bus.d_invalid    = w_en && !w_unmapped && w_hit && !w_pg[0];
    assign bus.d_modify     = w_en && !w_unmapped && w_hit && w_pg[0] && !w_pg[1] && w_we;
endmodule
